store_enc: RTL
==============

STORE_ENC -- requirements
Module: store_enc

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: address 32, data 32, byte strobe 4.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 st_valid  in  1  MEM-stage instruction valid.
REQ-005 opM  in  6  MEM-stage opcode; stores are `SB (101000), `SH (101001), `SW (101011); all others are non-stores.
REQ-006 addrM  in  32  effective address from ALU.
REQ-007 wdataM  in  32  rt value to store, unaligned (low bits significant).
REQ-008 flushM  in  1  pipeline flush; blocks acceptance of a new store.
REQ-009 stallM  out  1  pipeline stall request while a store is in progress.
REQ-010 st_done  out  1  one-cycle pulse when the store completes.
REQ-011 adesM  out  1  address-error-on-store flag, combinational.
REQ-012 badvaddrM  out  32  faulting address, valid when adesM=1.
REQ-013 data_req  out  1  SRAM-like request.
REQ-014 data_wr  out  1  write flag; 1 whenever data_req=1.
REQ-015 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-016 data_addr  out  32  full byte address.
REQ-017 data_wdata  out  32  lane-replicated write data.
REQ-018 data_wstrb  out  4  byte write enables; bit i selects bits 8i+7:8i.
REQ-019 data_addr_ok  in  1  slave accepted the request.
REQ-020 data_data_ok  in  1  slave completed the write.

Function
REQ-021 The block SHALL use an FSM with states IDLE, REQ and WAIT.
REQ-022 Accept condition (IDLE only): st_valid & store op & !flushM & !adesM; on accept, the block SHALL register addr, size, wdata and wstrb, and go to REQ.
REQ-023 Encoding for SB: wdata = {4{wdataM[7:0]}}, wstrb = 4'b0001 << addrM[1:0], size 0.
REQ-024 Encoding for SH: wdata = {2{wdataM[15:0]}}, wstrb 0011 if addrM[1]=0 else 1100, size 1.
REQ-025 Encoding for SW: wdata = wdataM, wstrb 1111, size 2.
REQ-026 adesM SHALL be st_valid & ((SH & addrM[0]) | (SW & addrM[1:0]!=0)); SB never faults. badvaddrM = addrM; no request is issued on fault.
REQ-027 In REQ: data_req=1; data_wr, data_addr, data_size, data_wdata and data_wstrb SHALL be held stable from registers until data_addr_ok.
REQ-028 REQ transitions: addr_ok & !data_ok -> WAIT; addr_ok & data_ok in the same cycle -> IDLE with st_done=1.
REQ-029 In WAIT: data_req=0; on data_data_ok -> IDLE with st_done=1; data_ok received in any other state SHALL be ignored.
REQ-030 stallM SHALL equal accept | (state==REQ) | (state==WAIT & !data_data_ok); latency is a minimum of 1 cycle after acceptance.
REQ-031 flushM SHALL NOT abort a request already in REQ or WAIT; the transaction completes normally.
REQ-032 Non-store ops and st_valid=0 SHALL produce no request, no stall and adesM=0.
REQ-033 Only one outstanding store is allowed; a new store is accepted only in IDLE, including in the cycle after st_done.

Reset
REQ-034 While resetn=0, the block SHALL set state=IDLE and data_req, stallM and st_done to 0; registered addr, wdata and wstrb SHALL be 0, and data_size SHALL be 0.
REQ-035 Reset asserted during REQ or WAIT SHALL return to IDLE immediately, with no st_done pulse.

Verification
REQ-036 SB, addrM=0x1003, wdataM=0x000000A5, addr_ok after 2 cycles, data_ok 1 cycle later -> wdata 0xA5A5A5A5, wstrb 1000, size 0, stall held until the data_ok cycle, and one st_done pulse.
REQ-037 SH, addrM=0x2002, wdataM=0x1234BEEF -> wdata 0xBEEFBEEF, wstrb 1100, size 1; then SW at 0x2004 -> wstrb 1111.
REQ-038 SW at 0x3001 and SH at 0x3003 -> adesM=1, badvaddr equals addrM, data_req stays 0, stallM=0; SB at 0x3003 -> no fault.
REQ-039 addr_ok and data_ok in the same cycle -> IDLE next cycle, one st_done pulse, and a back-to-back store accepted that cycle.
REQ-040 flushM in the accept cycle -> no request; flushM during WAIT -> transaction still completes with st_done.
REQ-041 resetn low mid-WAIT -> outputs go to 0 asynchronously, a later data_ok is ignored, and there is no st_done.

Source files
------------

// File: rtl/store_enc.sv
`default_nettype none
// store_enc: MEM-stage store encoder driving an SRAM-like write port (IDLE/REQ/WAIT).
// Rev 1.0 -- initial release.
module store_enc (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  input  logic [5:0]  opM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  output logic        stallM,
  output logic        st_done,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        done_q;
  logic        is_sb, is_sh, is_sw, accept;

  assign is_sb = (opM == OP_SB);
  assign is_sh = (opM == OP_SH);
  assign is_sw = (opM == OP_SW);

  assign adesM     = st_valid & ((is_sh & addrM[0]) | (is_sw & (addrM[1:0] != 2'b00)));
  assign badvaddrM = addrM;

  // Gated by resetn so no stall is requested while the block is held in reset.
  assign accept = resetn & (state_q == S_IDLE) & st_valid & (is_sb | is_sh | is_sw)
                  & ~flushM & ~adesM;

  always_comb begin
    wdata_d = wdataM;
    wstrb_d = 4'b1111;
    size_d  = 2'd2;
    if (is_sb) begin
      wdata_d = {4{wdataM[7:0]}};
      wstrb_d = 4'b0001 << addrM[1:0];
      size_d  = 2'd0;
    end else if (is_sh) begin
      wdata_d = {2{wdataM[15:0]}};
      wstrb_d = addrM[1] ? 4'b1100 : 4'b0011;
      size_d  = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      size_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_REQ;
            addr_q  <= addrM;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            size_q  <= size_d;
          end
        end
        S_REQ: begin
          // A data_ok without addr_ok here belongs to no transaction and is dropped.
          if (data_addr_ok) begin
            if (data_data_ok) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallM     = accept | (state_q == S_REQ) | ((state_q == S_WAIT) & ~data_data_ok);
  assign st_done    = done_q;
  assign data_req   = (state_q == S_REQ);
  assign data_wr    = data_req;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
endmodule
`default_nettype wire
